// File: rtl/quad_mixer_pkg.sv
// Shared types and constants for the quad-X motor mixer: FSM states and
// the per-motor sign table applied to roll, pitch and yaw.
package quad_mixer_pkg;

   typedef enum logic [1:0] {
      StDisarmed,
      StRamp,
      StArmed,
      StFailsafe
   } state_e;

   // Two guard bits keep a four-term signed sum from overflowing.
   localparam int SUM_EXTRA = 2;

   // Bit k-1 set: the term is added for motor k, otherwise subtracted.
   localparam logic [3:0] ROLL_ADD  = 4'b1001;
   localparam logic [3:0] PITCH_ADD = 4'b0011;
   localparam logic [3:0] YAW_ADD   = 4'b1010;

   function automatic int sum_width(input int n_rate);
      return n_rate + SUM_EXTRA;
   endfunction

endpackage

// File: rtl/mixer_clamp.sv
// Shifts one signed mixed sum and clamps it to the armed motor command
// window, flagging when the limit was applied.
module mixer_clamp #(
   parameter int SUM_W        = 18,
   parameter int SHIFT        = 0,
   parameter int N_MOTOR_RATE = 16,
   parameter int MOTOR_IDLE   = 100,
   parameter int MOTOR_MAX    = 2000
) (
   input  logic signed [SUM_W-1:0]        sum,
   output logic        [N_MOTOR_RATE-1:0] motor,
   output logic                           sat
);

   localparam logic signed [SUM_W-1:0] LO = SUM_W'(MOTOR_IDLE);
   localparam logic signed [SUM_W-1:0] HI = SUM_W'(MOTOR_MAX);

   logic signed [SUM_W-1:0] shifted;

   always_comb begin
      shifted = sum >>> SHIFT;
      sat     = 1'b0;
      motor   = N_MOTOR_RATE'(shifted);
      if (shifted < LO) begin
         motor = N_MOTOR_RATE'(MOTOR_IDLE);
         sat   = 1'b1;
      end else if (shifted > HI) begin
         motor = N_MOTOR_RATE'(MOTOR_MAX);
         sat   = 1'b1;
      end
   end

endmodule

// File: rtl/quad_motor_mixer.sv
// Quad-X motor mixer: arming FSM with spin-up ramp, two-stage mix/clamp
// pipeline and an input watchdog that forces failsafe.
module quad_motor_mixer
   import quad_mixer_pkg::*;
#(
   parameter int          N_RATE         = 16,
   parameter int          N_MOTOR_RATE   = 16,
   parameter int          SHIFT          = 0,
   parameter int          MOTOR_IDLE     = 100,
   parameter int          MOTOR_MAX      = 2000,
   parameter int          RAMP_STEP      = 10,
   parameter int unsigned TIMEOUT_CYCLES = 1000
) (
   input  logic                           sys_clk,
   input  logic                           reset,
   input  logic                           arm_req,
   input  logic                           in_valid,
   input  logic signed [N_RATE-1:0]       throttle_rate,
   input  logic signed [N_RATE-1:0]       yaw_rate,
   input  logic signed [N_RATE-1:0]       roll_rate,
   input  logic signed [N_RATE-1:0]       pitch_rate,
   output logic        [N_MOTOR_RATE-1:0] motor_1_rate,
   output logic        [N_MOTOR_RATE-1:0] motor_2_rate,
   output logic        [N_MOTOR_RATE-1:0] motor_3_rate,
   output logic        [N_MOTOR_RATE-1:0] motor_4_rate,
   output logic                           out_valid,
   output logic                           armed,
   output logic                           failsafe,
   output logic        [3:0]              sat_flags
);

   localparam int SW = sum_width(N_RATE);
   localparam int RW = N_MOTOR_RATE + 1;
   localparam logic [N_MOTOR_RATE-1:0] IDLE_CMD = N_MOTOR_RATE'(MOTOR_IDLE);

   state_e                   state_q, state_d;
   logic [N_MOTOR_RATE-1:0]  ramp_q, ramp_d, ramp_next;
   logic [RW-1:0]            ramp_sum;
   logic [31:0]              wdog_q, wdog_d;
   logic                     va_q, va_d;
   logic signed [SW-1:0]     sum_q [4];
   logic signed [SW-1:0]     sum_d [4];
   logic signed [SW-1:0]     mix [4];
   logic signed [SW-1:0]     t_x, r_x, p_x, y_x;
   logic [N_MOTOR_RATE-1:0]  motor_q [4];
   logic [N_MOTOR_RATE-1:0]  motor_d [4];
   logic [N_MOTOR_RATE-1:0]  clamp_val [4];
   logic [3:0]               clamp_sat;
   logic                     ov_q, ov_d;
   logic [3:0]               sat_q, sat_d;

   always_comb begin
      t_x = {{SUM_EXTRA{throttle_rate[N_RATE-1]}}, throttle_rate};
      r_x = {{SUM_EXTRA{roll_rate[N_RATE-1]}}, roll_rate};
      p_x = {{SUM_EXTRA{pitch_rate[N_RATE-1]}}, pitch_rate};
      y_x = {{SUM_EXTRA{yaw_rate[N_RATE-1]}}, yaw_rate};
      for (int k = 0; k < 4; k++) begin
         mix[k] = t_x + (ROLL_ADD[k]  ? r_x : -r_x)
                      + (PITCH_ADD[k] ? p_x : -p_x)
                      + (YAW_ADD[k]   ? y_x : -y_x);
      end
   end

   for (genvar k = 0; k < 4; k++) begin : g_clamp
      mixer_clamp #(
         .SUM_W        (SW),
         .SHIFT        (SHIFT),
         .N_MOTOR_RATE (N_MOTOR_RATE),
         .MOTOR_IDLE   (MOTOR_IDLE),
         .MOTOR_MAX    (MOTOR_MAX)
      ) u_clamp (
         .sum   (sum_q[k]),
         .motor (clamp_val[k]),
         .sat   (clamp_sat[k])
      );
   end

   always_comb begin
      ramp_sum  = {1'b0, ramp_q} + RW'(RAMP_STEP);
      ramp_next = (ramp_sum >= RW'(MOTOR_IDLE)) ? IDLE_CMD : ramp_sum[N_MOTOR_RATE-1:0];
   end

   always_comb begin
      state_d = state_q;
      ramp_d  = ramp_q;
      wdog_d  = wdog_q;
      va_d    = 1'b0;
      sum_d   = sum_q;
      motor_d = motor_q;
      ov_d    = 1'b0;
      sat_d   = sat_q;
      unique case (state_q)
         StDisarmed: begin
            ramp_d  = '0;
            wdog_d  = '0;
            motor_d = '{default: '0};
            sat_d   = '0;
            if (arm_req) state_d = StRamp;
         end
         StRamp: begin
            if (!arm_req) begin
               state_d = StDisarmed;
               ramp_d  = '0;
               motor_d = '{default: '0};
            end else begin
               ramp_d  = ramp_next;
               motor_d = '{default: ramp_next};
               ov_d    = 1'b1;
               if (ramp_next == IDLE_CMD) begin
                  state_d = StArmed;
                  wdog_d  = '0;
               end
            end
         end
         StArmed: begin
            // Any exit flushes the pipeline: va_d/ov_d stay at their 0 defaults.
            if (!arm_req) begin
               state_d = StDisarmed;
               motor_d = '{default: '0};
               sat_d   = '0;
            end else if (!in_valid && (wdog_q + 32'd1 >= TIMEOUT_CYCLES)) begin
               state_d = StFailsafe;
               motor_d = '{default: '0};
               sat_d   = '0;
            end else begin
               wdog_d = in_valid ? '0 : wdog_q + 32'd1;
               va_d   = in_valid;
               if (in_valid) sum_d = mix;
               if (va_q) begin
                  ov_d    = 1'b1;
                  motor_d = clamp_val;
                  sat_d   = clamp_sat;
               end
            end
         end
         StFailsafe: begin
            motor_d = '{default: '0};
            sat_d   = '0;
            if (!arm_req) state_d = StDisarmed;
         end
         default: state_d = StDisarmed;
      endcase
   end

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         state_q <= StDisarmed;
         ramp_q  <= '0;
         wdog_q  <= '0;
         va_q    <= 1'b0;
         sum_q   <= '{default: '0};
         motor_q <= '{default: '0};
         ov_q    <= 1'b0;
         sat_q   <= '0;
      end else begin
         state_q <= state_d;
         ramp_q  <= ramp_d;
         wdog_q  <= wdog_d;
         va_q    <= va_d;
         sum_q   <= sum_d;
         motor_q <= motor_d;
         ov_q    <= ov_d;
         sat_q   <= sat_d;
      end
   end

   assign motor_1_rate = motor_q[0];
   assign motor_2_rate = motor_q[1];
   assign motor_3_rate = motor_q[2];
   assign motor_4_rate = motor_q[3];
   assign out_valid    = ov_q;
   assign sat_flags    = sat_q;
   assign armed        = (state_q == StArmed);
   assign failsafe     = (state_q == StFailsafe);

endmodule

// File: tb/tb_quad_motor_mixer.sv
// Scoreboard bench for quad_motor_mixer: driver pushes expected motor
// commands from a plain-arithmetic model; a negedge monitor pops and compares.
module tb_quad_motor_mixer;

   localparam int IDLE    = 100;
   localparam int MAXC    = 2000;
   localparam int STEP    = 10;
   localparam int TIMEOUT = 1000;
   localparam int SH      = 0;

   logic               sys_clk = 1'b0;
   logic               reset = 1'b1;
   logic               arm_req = 1'b0;
   logic               in_valid = 1'b0;
   logic signed [15:0] throttle_rate = '0, yaw_rate = '0, roll_rate = '0, pitch_rate = '0;
   logic [15:0]        m1, m2, m3, m4;
   logic               out_valid, armed, failsafe;
   logic [3:0]         sat_flags;

   quad_motor_mixer #(
      .N_RATE         (16),
      .N_MOTOR_RATE   (16),
      .SHIFT          (SH),
      .MOTOR_IDLE     (IDLE),
      .MOTOR_MAX      (MAXC),
      .RAMP_STEP      (STEP),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .sys_clk       (sys_clk),
      .reset         (reset),
      .arm_req       (arm_req),
      .in_valid      (in_valid),
      .throttle_rate (throttle_rate),
      .yaw_rate      (yaw_rate),
      .roll_rate     (roll_rate),
      .pitch_rate    (pitch_rate),
      .motor_1_rate  (m1),
      .motor_2_rate  (m2),
      .motor_3_rate  (m3),
      .motor_4_rate  (m4),
      .out_valid     (out_valid),
      .armed         (armed),
      .failsafe      (failsafe),
      .sat_flags     (sat_flags)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      int         m [4];
      logic [3:0] sat;
      int         due;
   } exp_t;

   exp_t sb [$];
   exp_t last;
   bit   have_last = 1'b0;
   bit   in_armed = 1'b0;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_miss = 0;
   int   last_issue = 0;

   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint got, input longint exp);
      n_vec++;
      if (got != exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Reference: quad-X mixing formulas, then shift and clamp to [IDLE, MAXC].
   function automatic exp_t model(input int t, input int r, input int p, input int y,
                                  input int due);
      exp_t e;
      int   raw [4];
      int   s;
      raw[0] = t + r + p - y;
      raw[1] = t - r + p + y;
      raw[2] = t - r - p - y;
      raw[3] = t + r - p + y;
      e.sat = 4'b0000;
      e.due = due;
      for (int k = 0; k < 4; k++) begin
         s = raw[k] >>> SH;
         if (s < IDLE) begin
            e.m[k] = IDLE;
            e.sat[k] = 1'b1;
         end else if (s > MAXC) begin
            e.m[k] = MAXC;
            e.sat[k] = 1'b1;
         end else begin
            e.m[k] = s;
         end
      end
      return e;
   endfunction

   always @(negedge sys_clk) begin
      exp_t e;
      if (!reset) begin
         if (out_valid) begin
            if (sb.size() == 0) begin
               chk("unexpected_out_valid", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("latency_cycle", cyc, e.due);
               chk("motor_1", m1, e.m[0]);
               chk("motor_2", m2, e.m[1]);
               chk("motor_3", m3, e.m[2]);
               chk("motor_4", m4, e.m[3]);
               chk("sat_flags", sat_flags, e.sat);
               last = e;
               have_last = 1'b1;
            end
         end else if (in_armed && have_last) begin
            chk("hold_motor_1", m1, last.m[0]);
            chk("hold_motor_4", m4, last.m[3]);
         end
      end
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic apply(input int t, input int r, input int p, input int y);
      throttle_rate = 16'(t);
      roll_rate     = 16'(r);
      pitch_rate    = 16'(p);
      yaw_rate      = 16'(y);
      in_valid      = 1'b1;
      sb.push_back(model(t, r, p, y, cyc + 2));
      last_issue = cyc;
      tick();
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) tick();
   endtask

   // Pushes the ramp sequence; returns how many ramp steps to expect.
   function automatic int push_ramp(input int c);
      exp_t e;
      int   r = 0;
      int   n = 0;
      while (r < IDLE) begin
         r = (r + STEP > IDLE) ? IDLE : r + STEP;
         n++;
         e.m = '{r, r, r, r};
         e.sat = 4'b0000;
         e.due = c + 1 + n;
         sb.push_back(e);
      end
      return n;
   endfunction

   task automatic arm_and_ramp();
      int n;
      arm_req = 1'b1;
      n = push_ramp(cyc);
      repeat (n) tick();
      chk("armed_during_ramp", armed, 0);
      tick();
      chk("armed_after_ramp", armed, 1);
      in_armed = 1'b1;
   endtask

   function automatic int rnd(input int lo, input int hi);
      return lo + int'($urandom_range(hi - lo));
   endfunction

   initial begin
      int c;
      #3;
      chk("reset_motor_1", m1, 0);
      chk("reset_motor_2", m2, 0);
      chk("reset_motor_3", m3, 0);
      chk("reset_motor_4", m4, 0);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_armed", armed, 0);
      chk("reset_failsafe", failsafe, 0);
      chk("reset_sat_flags", sat_flags, 0);
      tick();
      reset = 1'b0;
      tick();

      arm_and_ramp();

      apply(500, 50, 20, 10);
      idle(3);
      apply(1990, 50, 0, 0);
      idle(2);
      apply(0, 0, 0, 0);
      apply(-300, 0, 0, 0);
      idle(3);

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(3) == 0)
            apply(int'($signed(16'($urandom()))), int'($signed(16'($urandom()))),
                  int'($signed(16'($urandom()))), int'($signed(16'($urandom()))));
         else
            apply(rnd(-500, 2500), rnd(-600, 600), rnd(-600, 600), rnd(-600, 600));
         if ($urandom_range(2) == 0) idle(rnd(1, 4));
      end
      in_valid = 1'b0;

      // Watchdog: failsafe exactly TIMEOUT edges after the last accepted input.
      in_armed = 1'b0;
      for (int i = 0; i < TIMEOUT + 100 && !failsafe; i++) tick();
      chk("failsafe_asserted", failsafe, 1);
      chk("failsafe_cycle", cyc, last_issue + 1 + TIMEOUT);
      chk("failsafe_armed", armed, 0);
      chk("failsafe_motor_1", m1, 0);
      chk("failsafe_motor_3", m3, 0);
      chk("failsafe_out_valid", out_valid, 0);
      chk("failsafe_sat_flags", sat_flags, 0);
      apply(800, 0, 0, 0);
      void'(sb.pop_back());
      in_valid = 1'b0;
      tick();
      chk("failsafe_ignores_input", m2, 0);
      arm_req = 1'b0;
      tick();
      chk("disarm_from_failsafe", failsafe, 0);
      arm_and_ramp();

      // Back-to-back inputs with arm_req dropping on the second: all flushed.
      in_armed = 1'b0;
      throttle_rate = 16'sd700;
      in_valid = 1'b1;
      tick();
      throttle_rate = 16'sd900;
      arm_req = 1'b0;
      tick();
      throttle_rate = 16'sd1100;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("flush_out_valid", out_valid, 0);
         chk("flush_motors", m1 + m2 + m3 + m4, 0);
         chk("flush_armed", armed, 0);
         tick();
      end

      // Reset asserted mid-ramp clears outputs without waiting for a clock edge.
      arm_req = 1'b1;
      c = push_ramp(cyc);
      repeat (4) tick();
      chk("midramp_motor_1", m1, 3 * STEP);
      #2;
      reset = 1'b1;
      #1;
      chk("async_reset_motor_1", m1, 0);
      chk("async_reset_motor_4", m4, 0);
      chk("async_reset_out_valid", out_valid, 0);
      sb.delete();
      arm_req = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      repeat (3) tick();
      chk("disarmed_after_reset", out_valid, 0);
      chk("scoreboard_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
